// File: rtl/uart_bus_regs_pkg.sv
// Shared definitions for the UART register front end: register map, STATUS/CTRL
// bit positions and the TX issue FSM encoding.
package uart_bus_regs_pkg;

  localparam logic [1:0] ADDR_DATA        = 2'd0;
  localparam logic [1:0] ADDR_STATUS      = 2'd1;
  localparam logic [1:0] ADDR_DIV_LO      = 2'd2;
  localparam logic [1:0] ADDR_DIV_HI_CTRL = 2'd3;

  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_TX_FULL     = 1;
  localparam int ST_TX_IDLE     = 2;
  localparam int ST_RX_OVR      = 3;
  localparam int ST_TX_OVF      = 4;

  localparam int CTRL_RX_IE = 6;
  localparam int CTRL_TX_IE = 7;

  typedef enum logic [1:0] {
    TX_IDLE       = 2'd0,
    TX_WAIT_START = 2'd1,
    TX_BUSY       = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_bus_regs_if.sv
// CPU-side register bus between the bus decoder (master) and uart_bus_regs (slave).
interface uart_bus_regs_if;
  // bus_we/bus_re are single-cycle strobes with no back-pressure, never both high;
  // bus_rdata is valid the cycle after bus_re and holds until the next read.
  logic [1:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata;

  modport master (output bus_addr, output bus_wdata, output bus_we, output bus_re,
                  input bus_rdata);
  modport slave  (input bus_addr, input bus_wdata, input bus_we, input bus_re,
                  output bus_rdata);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/uart_bus_regs.sv
// Register front end for uart_core: DATA/STATUS/DIV_LO/DIV_HI_CTRL bus slave,
// TX/RX byte FIFOs, one-byte-in-flight TX issue FSM and RX accept/ack logic.
module uart_bus_regs
  import uart_bus_regs_pkg::*;
#(
  parameter int          FIFO_DEPTH_LOG2 = 2,
  parameter logic [11:0] DIVIDER_RESET   = 12'd103
) (
  input  logic              clk,
  input  logic              rst,
  uart_bus_regs_if.slave    bus,
  output logic              irq,
  output logic [11:0]       divider,
  output logic [7:0]        data_tx,
  output logic              have_data_tx,
  input  logic              transmitting,
  input  logic [7:0]        data_rx,
  input  logic              have_data_rx,
  output logic              data_rx_ack,
  output tx_state_t         tx_state_dbg
);
  logic       wr_data, rd_data, wr_status, wr_div_lo, wr_div_hi;
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] tx_head, rx_head;
  logic       rx_ovr, tx_ovf, rx_ie, tx_ie, tx_idle;
  logic [7:0] status;
  tx_state_t  tx_state;

  assign wr_data   = bus.bus_we && (bus.bus_addr == ADDR_DATA);
  assign rd_data   = bus.bus_re && (bus.bus_addr == ADDR_DATA);
  assign wr_status = bus.bus_we && (bus.bus_addr == ADDR_STATUS);
  assign wr_div_lo = bus.bus_we && (bus.bus_addr == ADDR_DIV_LO);
  assign wr_div_hi = bus.bus_we && (bus.bus_addr == ADDR_DIV_HI_CTRL);

  assign tx_push = wr_data;
  assign tx_pop  = (tx_state == TX_IDLE) && !tx_empty && !transmitting;
  assign tx_idle = tx_empty && (tx_state == TX_IDLE) && !transmitting;
  // The registered ack masks the still-high have_data_rx during the ack cycle.
  assign rx_push = have_data_rx && !data_rx_ack;
  assign rx_pop  = rd_data && !rx_empty;
  assign tx_state_dbg = tx_state;

  always_comb begin
    status                 = '0;
    status[ST_RX_NONEMPTY] = !rx_empty;
    status[ST_TX_FULL]     = tx_full;
    status[ST_TX_IDLE]     = tx_idle;
    status[ST_RX_OVR]      = rx_ovr;
    status[ST_TX_OVF]      = tx_ovf;
  end

  uart_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(bus.bus_wdata),
    .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(data_rx),
    .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state     <= TX_IDLE;
      data_tx      <= '0;
      have_data_tx <= 1'b0;
    end else begin
      have_data_tx <= 1'b0;
      case (tx_state)
        TX_IDLE: if (tx_pop) begin
          data_tx      <= tx_head;
          have_data_tx <= 1'b1;
          tx_state     <= TX_WAIT_START;
        end
        TX_WAIT_START: if (transmitting)  tx_state <= TX_BUSY;
        TX_BUSY:       if (!transmitting) tx_state <= TX_IDLE;
        default:       tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      divider     <= DIVIDER_RESET;
      rx_ie       <= 1'b0;
      tx_ie       <= 1'b0;
      rx_ovr      <= 1'b0;
      tx_ovf      <= 1'b0;
      bus.bus_rdata <= '0;
      data_rx_ack <= 1'b0;
      irq         <= 1'b0;
    end else begin
      data_rx_ack <= rx_push;
      irq         <= (rx_ie && !rx_empty) || (tx_ie && tx_idle);
      // A hardware set in the same cycle as a software clear wins.
      rx_ovr <= (rx_push && rx_full && !rx_pop) ||
                (rx_ovr && !(wr_status && bus.bus_wdata[ST_RX_OVR]));
      tx_ovf <= (tx_push && tx_full && !tx_pop) ||
                (tx_ovf && !(wr_status && bus.bus_wdata[ST_TX_OVF]));
      if (wr_div_lo) divider[7:0] <= bus.bus_wdata;
      if (wr_div_hi) begin
        divider[11:8] <= bus.bus_wdata[3:0];
        rx_ie         <= bus.bus_wdata[CTRL_RX_IE];
        tx_ie         <= bus.bus_wdata[CTRL_TX_IE];
      end
      if (bus.bus_re) begin
        case (bus.bus_addr)
          ADDR_DATA:   bus.bus_rdata <= rx_empty ? 8'h00 : rx_head;
          ADDR_STATUS: bus.bus_rdata <= status;
          ADDR_DIV_LO: bus.bus_rdata <= divider[7:0];
          default:     bus.bus_rdata <= {tx_ie, rx_ie, 2'b00, divider[11:8]};
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_bus_regs.sv
// Bench for uart_bus_regs: behavioural loopback core, cycle-level reference model
// with a single compare process, and directed register-level scenarios.
module tb_uart_bus_regs;
  import uart_bus_regs_pkg::*;

  localparam int DEPTH = 4;
  localparam int FRAME = 20;

  logic        clk;
  logic        rst;
  logic        irq;
  logic [11:0] divider;
  logic [7:0]  data_tx;
  logic        have_data_tx;
  logic        transmitting;
  logic [7:0]  data_rx;
  logic        have_data_rx;
  logic        data_rx_ack;
  tx_state_t   tx_state_dbg;

  uart_bus_regs_if bus ();

  uart_bus_regs #(.FIFO_DEPTH_LOG2(2), .DIVIDER_RESET(12'd103)) dut (
    .clk(clk), .rst(rst), .bus(bus), .irq(irq), .divider(divider),
    .data_tx(data_tx), .have_data_tx(have_data_tx), .transmitting(transmitting),
    .data_rx(data_rx), .have_data_rx(have_data_rx), .data_rx_ack(data_rx_ack),
    .tx_state_dbg(tx_state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- loopback core model ----------------
  logic       c_rst, c_drop;
  logic [7:0] c_byte;
  int         c_cnt;
  initial begin
    transmitting = 1'b0; have_data_rx = 1'b0; data_rx = 8'h00;
    c_drop = 1'b0; c_cnt = 0; c_byte = 8'h00;
    forever begin
      @(posedge clk);
      c_rst = rst;
      #1;
      if (c_rst) begin
        transmitting = 1'b0; have_data_rx = 1'b0; c_drop = 1'b0; c_cnt = 0;
      end else begin
        if (c_drop) begin
          have_data_rx = 1'b0; c_drop = 1'b0;
        end else if (have_data_rx && data_rx_ack) begin
          c_drop = 1'b1;
        end
        if (have_data_tx) begin
          c_byte = data_tx; c_cnt = FRAME; transmitting = 1'b1;
        end else if (transmitting) begin
          c_cnt--;
          if (c_cnt == 0) begin
            transmitting = 1'b0; data_rx = c_byte; have_data_rx = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- reference model + compare process ----------------
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  exp_rx_q[$];
  logic        m_in_flight, m_seen_start, m_rx_ovr, m_tx_ovf, m_rx_ie, m_tx_ie, m_ack;
  logic [11:0] m_div;
  logic        p_rst = 1'b1, p_we = 1'b0, p_re = 1'b0, p_hrx = 1'b0, p_trans = 1'b0;
  logic [1:0]  p_addr = 2'd0;
  logic [7:0]  p_wdata = 8'h00, p_drx = 8'h00;
  int          n_issue = 0, n_ack = 0;
  int          tx_sz, rx_sz;
  logic        issue, tx_idle_m, exp_irq, rx_push_m, rx_pop_m, tx_set, rx_set;
  logic [7:0]  status_m, exp_rd;

  initial begin
    forever begin
      @(negedge clk);
      if (have_data_tx) n_issue++;
      if (data_rx_ack)  n_ack++;
      if (p_rst) begin
        exp_tx_q.delete(); exp_rx_q.delete();
        m_in_flight = 0; m_seen_start = 0; m_rx_ovr = 0; m_tx_ovf = 0;
        m_rx_ie = 0; m_tx_ie = 0; m_ack = 0; m_div = 12'd103;
        check("rst_have_data_tx", have_data_tx, 0);
        check("rst_data_rx_ack", data_rx_ack, 0);
        check("rst_irq", irq, 0);
        check("rst_divider", divider, 12'd103);
        check("rst_rdata", bus.bus_rdata, 0);
      end else begin
        tx_sz     = exp_tx_q.size();
        rx_sz     = exp_rx_q.size();
        issue     = !m_in_flight && (tx_sz > 0) && !p_trans;
        tx_idle_m = (tx_sz == 0) && !m_in_flight && !p_trans;
        status_m  = {3'b000, m_tx_ovf, m_rx_ovr, tx_idle_m, (tx_sz == DEPTH), (rx_sz != 0)};
        exp_irq   = (m_rx_ie && rx_sz != 0) || (m_tx_ie && tx_idle_m);
        rx_push_m = p_hrx && !m_ack;
        rx_pop_m  = p_re && (p_addr == 2'd0) && (rx_sz != 0);
        case (p_addr)
          2'd0:    exp_rd = (rx_sz != 0) ? exp_rx_q[0] : 8'h00;
          2'd1:    exp_rd = status_m;
          2'd2:    exp_rd = m_div[7:0];
          default: exp_rd = {m_tx_ie, m_rx_ie, 2'b00, m_div[11:8]};
        endcase

        check("have_data_tx", have_data_tx, issue);
        if (issue) check("data_tx", data_tx, exp_tx_q[0]);
        check("data_rx_ack", data_rx_ack, rx_push_m);
        check("irq", irq, exp_irq);
        if (p_re) check("bus_rdata", bus.bus_rdata, exp_rd);

        if (issue) void'(exp_tx_q.pop_front());
        tx_set = 0;
        if (p_we && p_addr == 2'd0) begin
          if (tx_sz < DEPTH || issue) exp_tx_q.push_back(p_wdata);
          else tx_set = 1;
        end
        m_tx_ovf = tx_set || (m_tx_ovf && !(p_we && p_addr == 2'd1 && p_wdata[4]));
        if (rx_pop_m) void'(exp_rx_q.pop_front());
        rx_set = 0;
        if (rx_push_m) begin
          if (rx_sz < DEPTH || rx_pop_m) exp_rx_q.push_back(p_drx);
          else rx_set = 1;
        end
        m_rx_ovr = rx_set || (m_rx_ovr && !(p_we && p_addr == 2'd1 && p_wdata[3]));
        m_ack = rx_push_m;

        if (issue) begin
          m_in_flight = 1; m_seen_start = 0;
        end else if (m_in_flight && !m_seen_start && p_trans) begin
          m_seen_start = 1;
        end else if (m_in_flight && m_seen_start && !p_trans) begin
          m_in_flight = 0;
        end

        if (p_we && p_addr == 2'd2) m_div[7:0] = p_wdata;
        if (p_we && p_addr == 2'd3) begin
          m_div[11:8] = p_wdata[3:0]; m_rx_ie = p_wdata[6]; m_tx_ie = p_wdata[7];
        end
        check("divider", divider, m_div);
      end
      p_rst = rst; p_we = bus.bus_we; p_re = bus.bus_re; p_addr = bus.bus_addr;
      p_wdata = bus.bus_wdata; p_hrx = have_data_rx; p_drx = data_rx; p_trans = transmitting;
    end
  end

  // ---------------- driver tasks (entered at posedge+1) ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    bus.bus_addr = a; bus.bus_wdata = d; bus.bus_we = 1'b1;
    @(posedge clk); #1;
    bus.bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    bus.bus_addr = a; bus.bus_re = 1'b1;
    @(posedge clk); #1;
    bus.bus_re = 1'b0;
    d = bus.bus_rdata;
  endtask

  // ---------------- directed scenarios ----------------
  logic [7:0] rd;
  int base_issue, base_ack;
  logic [7:0] t3_bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  initial begin
    rst = 1'b1;
    bus.bus_addr = 2'd0; bus.bus_wdata = 8'h00; bus.bus_we = 1'b0; bus.bus_re = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset values
    bus_read(2'd1, rd); check("t1_status", rd, 8'h04);
    bus_read(2'd2, rd); check("t1_div_lo", rd, 8'h67);
    bus_read(2'd3, rd); check("t1_div_hi", rd, 8'h00);
    bus_read(2'd0, rd); check("t1_data_empty", rd, 8'h00);
    check("t1_irq", irq, 0);
    bus_write(2'd2, 8'h04); bus_write(2'd3, 8'h00);
    bus_read(2'd2, rd); check("t1_div_lo_wr", rd, 8'h04);
    check("t1_divider_out", divider, 12'h004);

    // two-byte loopback
    base_issue = n_issue; base_ack = n_ack;
    bus_write(2'd0, 8'hA5); bus_write(2'd0, 8'h3C);
    wait_cycles(80);
    check("t2_issue_count", n_issue - base_issue, 2);
    check("t2_ack_count", n_ack - base_ack, 2);
    bus_read(2'd0, rd); check("t2_rx0", rd, 8'hA5);
    bus_read(2'd0, rd); check("t2_rx1", rd, 8'h3C);
    bus_read(2'd0, rd); check("t2_rx_empty", rd, 8'h00);

    // TX overflow and RX overrun
    base_issue = n_issue; base_ack = n_ack;
    for (int i = 0; i < 6; i++) bus_write(2'd0, t3_bytes[i]);
    bus_read(2'd1, rd); check("t3_status_ovf", rd, 8'h12);
    bus_write(2'd1, 8'h10);
    bus_read(2'd1, rd); check("t3_status_ovf_clr", rd, 8'h02);
    wait_cycles(200);
    check("t3_issue_count", n_issue - base_issue, 5);
    check("t3_ack_count", n_ack - base_ack, 5);
    bus_read(2'd1, rd); check("t3_status_ovr", rd, 8'h0D);
    for (int i = 0; i < 4; i++) begin
      bus_read(2'd0, rd); check("t3_rx_order", rd, t3_bytes[i]);
    end
    bus_read(2'd0, rd); check("t3_rx_empty", rd, 8'h00);
    bus_write(2'd1, 8'h08);
    bus_read(2'd1, rd); check("t3_status_clr", rd, 8'h04);

    // interrupts
    bus_write(2'd3, 8'h40);
    bus_write(2'd0, 8'h5A);
    wait_cycles(60);
    check("t5_irq_rx", irq, 1);
    bus_read(2'd0, rd); check("t5_rx", rd, 8'h5A);
    wait_cycles(1);
    check("t5_irq_fall", irq, 0);
    bus_write(2'd3, 8'h80);
    wait_cycles(2);
    check("t5_irq_tx", irq, 1);
    bus_write(2'd3, 8'h00);

    // reset mid-frame with bytes queued
    for (int i = 0; i < 4; i++) bus_write(2'd0, 8'hC0 + 8'(i));
    wait_cycles(5);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    base_issue = n_issue;
    check("t6_have_data_tx", have_data_tx, 0);
    bus_read(2'd1, rd); check("t6_status", rd, 8'h04);
    wait_cycles(100);
    check("t6_no_frames", n_issue - base_issue, 0);
    check("t6_divider", divider, 12'd103);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
